pci_master_ctrl: RTL and testbench
==================================

Name: pci_master_ctrl

Overview:
Per-agent PCI initiator control FSM; sits directly upstream of pci_arbiter and drives one of its REQn inputs while consuming the matching GNTn. Accepts a local transfer command, requests the bus, waits for grant plus bus idle, then runs the address phase and a counted burst of data phases. Terminates on completion, target retry/disconnect, target abort or master-abort timeout. Reports the outcome to the local side.

Parameters:
CNT_W, 5, width of burst_len and beat counter (max burst 2^CNT_W-1)
DEVSEL_TIMEOUT, 5, DATA cycles without DEVSEL_n low before master abort (>=1)

Ports:
clk  in  1  bus clock
reset_n  in  1  asynchronous active-low reset
start  in  1  level; command valid, sampled only in IDLE
burst_len  in  CNT_W  data phases requested; 0 treated as 1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on return to IDLE
status  out  2  00 ok, 01 target abort, 10 master abort, 11 retry/disconnect; held until next done
beats_done  out  CNT_W  data phases completed in last transfer; held until next start accept
REQ  out  1  active-high bus request to arbiter
GNT  in  1  active-high grant from arbiter
FRAME_in_n  in  1  observed bus FRAME#
IRDY_in_n  in  1  observed bus IRDY#
TRDY_n  in  1  target ready
STOP_n  in  1  target stop
DEVSEL_n  in  1  device select
FRAME_out_n  out  1  driven FRAME#
IRDY_out_n  out  1  driven IRDY#
ctl_oe  out  1  output enable for FRAME#/IRDY#
addr_phase  out  1  high during address phase (AD/CBE drive strobe)
data_ack  out  1  high in a cycle where a data phase completes (IRDY low and TRDY low and DEVSEL low)

Behaviour:
- Reset (async, any state): state IDLE; REQ=0, FRAME_out_n=1, IRDY_out_n=1, ctl_oe=0, addr_phase=0, busy=0, done=0, status=00, beats_done=0. Takes effect immediately, including mid-burst.
- All outputs registered, Moore-style: asserted in the cycle the state is entered. data_ack is combinational from the inputs, gated by state==DATA.
- IDLE: start=1 -> REQ_WAIT. On that edge: latch len = (burst_len==0) ? 1 : burst_len; clear beats_done.
- REQ_WAIT: REQ=1, busy=1. Advance to ADDR only when GNT=1 && FRAME_in_n=1 && IRDY_in_n=1 in the same cycle. A grant without an idle bus, or an idle bus without a grant, holds the state.
- ADDR, exactly 1 cycle: FRAME_out_n=0, ctl_oe=1, addr_phase=1, REQ=1. Next state DATA; load remaining=len; clear devsel_cnt.
- DATA: IRDY_out_n=0, ctl_oe=1, REQ=1.
  - FRAME_out_n=0 while remaining>1; FRAME_out_n=1 when remaining==1 (last phase).
  - devsel_cnt increments each cycle DEVSEL_n=1 and freezes once DEVSEL_n=0 is seen.
  - Priority, evaluated each cycle:
    1. DEVSEL_n=1 && devsel_cnt==DEVSEL_TIMEOUT-1 -> TURN, status 10.
    2. DEVSEL_n=1 && STOP_n=0 && devsel seen earlier -> TURN, status 01.
    3. TRDY_n=0 && DEVSEL_n=0: beat completes, beats_done+1, remaining-1. remaining==1 -> TURN, status 00; else if STOP_n=0 -> TURN, status 11; else stay.
    4. STOP_n=0 && TRDY_n=1 && DEVSEL_n=0 -> TURN, status 11.
    5. Otherwise wait states; stay.
- GNT removal during ADDR/DATA is ignored; the transfer completes.
- TURN, 1 cycle: FRAME_out_n=1, IRDY_out_n=1, ctl_oe=1 (drive high), REQ=0. Next state IDLE.
- IDLE entry from TURN: ctl_oe=0, done=1 for one cycle, status updated that same cycle.
- start high in the done cycle is accepted: back-to-back transfer, REQ reasserts the next cycle.

Decomposition:
- Shared package pci_arb_pkg: state encoding constants (IDLE, REQ_WAIT, ADDR, DATA, TURN) and status codes (ST_OK, ST_TABORT, ST_MABORT, ST_RETRY); the arbiter also uses this package.
- One sub-module: pci_devsel_timer, the saturating DEVSEL_TIMEOUT counter with clear/enable and an expired flag.

Test Plan:
- burst_len=4, GNT high, bus idle, target DEVSEL on cycle 1 and TRDY every cycle -> ADDR 1 cycle; 4 data_ack; FRAME_out_n high only on beat 4; done; status 00; beats_done 4.
- burst_len=3, bus busy (FRAME_in_n=0) for 5 cycles while GNT=1 -> stay in REQ_WAIT with REQ=1; ADDR on the first idle cycle.
- burst_len=2, DEVSEL_n never low -> TURN after 5 DATA cycles; status 10; beats_done 0.
- burst_len=8, STOP_n=0 with TRDY_n=0 on beat 3 -> status 11; beats_done 3.
- burst_len=4, DEVSEL seen, then DEVSEL_n=1 and STOP_n=0 -> status 01.
- reset_n low mid-DATA -> all outputs reach reset values immediately; burst_len=0 on the next start gives a 1-beat transfer.

Source files
------------

// File: rtl/pci_arb_pkg.sv
// Shared PCI bus-agent definitions: FSM state encoding and transfer status codes.
// Used by the initiator control FSM and by the arbiter.
package pci_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_WAIT = 3'd1,
        ADDR     = 3'd2,
        DATA     = 3'd3,
        TURN     = 3'd4
    } pci_state_t;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_TABORT = 2'b01;
    localparam logic [1:0] ST_MABORT = 2'b10;
    localparam logic [1:0] ST_RETRY  = 2'b11;

endpackage

// File: rtl/pci_devsel_timer.sv
// Saturating DEVSEL# wait counter; flags expiry at TIMEOUT-1 counted cycles.
// Latency: count registered, expired is combinational from the count.
// Backpressure: none; en advances, clr restarts, count holds at the limit.
module pci_devsel_timer #(
    parameter int TIMEOUT = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    assign expired = (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pci_master_ctrl.sv
// PCI initiator control FSM: request, address phase, counted data burst, turnaround.
// Latency: all outputs registered Moore-style except data_ack (combinational, DATA only).
// Backpressure: holds in REQ_WAIT until granted and bus idle; target wait states stretch DATA.
module pci_master_ctrl
    import pci_arb_pkg::*;
#(
    parameter int CNT_W          = 5,
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] beats_done,
    output logic             REQ,
    input  logic             GNT,
    input  logic             FRAME_in_n,
    input  logic             IRDY_in_n,
    input  logic             TRDY_n,
    input  logic             STOP_n,
    input  logic             DEVSEL_n,
    output logic             FRAME_out_n,
    output logic             IRDY_out_n,
    output logic             ctl_oe,
    output logic             addr_phase,
    output logic             data_ack
);

    pci_state_t       state, state_nxt;
    logic [CNT_W-1:0] len, remaining, rem_nxt;
    logic [1:0]       term_st, term_nxt;
    logic             devsel_seen, beat, tmr_expired;

    pci_devsel_timer #(
        .TIMEOUT (DEVSEL_TIMEOUT)
    ) u_devsel_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state == ADDR),
        .en      ((state == DATA) && DEVSEL_n && !devsel_seen),
        .expired (tmr_expired)
    );

    assign data_ack = (state == DATA) && !IRDY_out_n && !TRDY_n && !DEVSEL_n;

    // Termination priority: timeout, target abort, completed beat, stop without data.
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        term_nxt  = term_st;
        beat      = 1'b0;
        case (state)
            IDLE:     if (start) state_nxt = REQ_WAIT;
            REQ_WAIT: if (GNT && FRAME_in_n && IRDY_in_n) state_nxt = ADDR;
            ADDR: begin
                state_nxt = DATA;
                rem_nxt   = len;
            end
            DATA: begin
                if (DEVSEL_n && tmr_expired) begin
                    state_nxt = TURN;
                    term_nxt  = ST_MABORT;
                end else if (DEVSEL_n && !STOP_n && devsel_seen) begin
                    state_nxt = TURN;
                    term_nxt  = ST_TABORT;
                end else if (!TRDY_n && !DEVSEL_n) begin
                    beat    = 1'b1;
                    rem_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = TURN;
                        term_nxt  = ST_OK;
                    end else if (!STOP_n) begin
                        state_nxt = TURN;
                        term_nxt  = ST_RETRY;
                    end
                end else if (!STOP_n && !DEVSEL_n) begin
                    state_nxt = TURN;
                    term_nxt  = ST_RETRY;
                end
            end
            TURN:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            len         <= CNT_W'(1);
            remaining   <= '0;
            term_st     <= ST_OK;
            devsel_seen <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            status      <= ST_OK;
            beats_done  <= '0;
            REQ         <= 1'b0;
            FRAME_out_n <= 1'b1;
            IRDY_out_n  <= 1'b1;
            ctl_oe      <= 1'b0;
            addr_phase  <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            term_st   <= term_nxt;
            if (state == IDLE && start) begin
                len        <= (burst_len == '0) ? CNT_W'(1) : burst_len;
                beats_done <= '0;
            end else if (beat) begin
                beats_done <= beats_done + CNT_W'(1);
            end
            if (state == ADDR)
                devsel_seen <= 1'b0;
            else if (state == DATA && !DEVSEL_n)
                devsel_seen <= 1'b1;
            if (state == TURN)
                status <= term_st;
            // Outputs reflect the state being entered, so they are valid in its first cycle.
            busy        <= (state_nxt != IDLE);
            done        <= (state == TURN);
            REQ         <= (state_nxt inside {REQ_WAIT, ADDR, DATA});
            FRAME_out_n <= !((state_nxt == ADDR) || (state_nxt == DATA && rem_nxt > CNT_W'(1)));
            IRDY_out_n  <= (state_nxt != DATA);
            ctl_oe      <= (state_nxt inside {ADDR, DATA, TURN});
            addr_phase  <= (state_nxt == ADDR);
        end
    end

endmodule

// File: tb/tb_pci_master_ctrl.sv
// Randomized bench for pci_master_ctrl: scripted target/arbiter, transaction-level
// reference model feeding a scoreboard that a separate monitor drains on done.
module tb_pci_master_ctrl;

    localparam int CNT_W = 5;
    localparam int TMO   = 5;

    logic             clk = 1'b0;
    logic             reset_n, start, GNT, FRAME_in_n, IRDY_in_n, TRDY_n, STOP_n, DEVSEL_n;
    logic [CNT_W-1:0] burst_len, beats_done;
    logic             busy, done, REQ, FRAME_out_n, IRDY_out_n, ctl_oe, addr_phase, data_ack;
    logic [1:0]       status;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int le;
        int st;
        int beats;
        int ncyc;
    } exp_t;

    exp_t exp_q[$];

    // Current target/arbiter script.
    int s_len, s_dev, s_stop, s_disc, s_abort, s_gnt, s_bf, s_bi;
    bit trdy_pat[64];

    always #5 clk = ~clk;

    pci_master_ctrl #(.CNT_W(CNT_W), .DEVSEL_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .beats_done  (beats_done),
        .REQ         (REQ),
        .GNT         (GNT),
        .FRAME_in_n  (FRAME_in_n),
        .IRDY_in_n   (IRDY_in_n),
        .TRDY_n      (TRDY_n),
        .STOP_n      (STOP_n),
        .DEVSEL_n    (DEVSEL_n),
        .FRAME_out_n (FRAME_out_n),
        .IRDY_out_n  (IRDY_out_n),
        .ctl_oe      (ctl_oe),
        .addr_phase  (addr_phase),
        .data_ack    (data_ack)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the target script one data cycle at a time and apply the termination rules.
    function automatic void model(output int st, output int bt, output int nc);
        int le;
        le = (s_len == 0) ? 1 : s_len;
        st = -1;
        bt = 0;
        nc = 0;
        for (int c = 0; c < 64; c++) begin
            nc = c + 1;
            if (c < s_dev) begin
                if (c == TMO - 1) begin st = 2; return; end
            end else if (s_abort > 0 && c >= s_abort) begin
                st = 1; return;
            end else if (c == s_disc) begin
                st = 3; return;
            end else if (trdy_pat[c]) begin
                bt++;
                if (bt == le) begin st = 0; return; end
                if (bt == s_stop) begin st = 3; return; end
            end
        end
    endfunction

    // Arbiter and target driver, reacting to the DUT's registered outputs.
    int w = 0, c = 0, tb_beats = 0;
    bit aborting;
    initial begin
        GNT = 0; FRAME_in_n = 1; IRDY_in_n = 1; TRDY_n = 1; STOP_n = 1; DEVSEL_n = 1;
        forever begin
            @(posedge clk); #1;
            GNT = 0; FRAME_in_n = 1; IRDY_in_n = 1; TRDY_n = 1; STOP_n = 1; DEVSEL_n = 1;
            if (REQ && !ctl_oe) begin
                GNT        = (w >= s_gnt);
                FRAME_in_n = !(w < s_bf);
                IRDY_in_n  = !(w < s_bi);
                w++;
            end else begin
                w = 0;
            end
            if (addr_phase) begin
                c = 0;
                tb_beats = 0;
                GNT = 1'($urandom_range(1));
            end else if (!IRDY_out_n) begin
                GNT = 1'($urandom_range(1));
                aborting = (s_abort > 0) && (c >= s_abort);
                if (c < s_dev || aborting) begin
                    STOP_n = !aborting;
                end else begin
                    DEVSEL_n = 0;
                    if (c == s_disc) begin
                        STOP_n = 0;
                    end else if (c >= 64 || trdy_pat[c % 64]) begin
                        TRDY_n = 0;
                        tb_beats++;
                        STOP_n = !(tb_beats == s_stop);
                    end
                end
                c++;
            end
        end
    end

    // Monitor: per-cycle protocol checks plus scoreboard compare on every done pulse.
    int dcyc = 0, acks = 0, acyc = 0;
    bit p_rw = 0, p_go = 0, p_idle = 0, p_start = 0;
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                dcyc = 0; acks = 0; acyc = 0;
                p_rw = 0; p_go = 0; p_idle = 0; p_start = 0;
                continue;
            end
            if (p_rw) begin
                check("addr_after_req_wait", addr_phase, p_go);
                if (!p_go) check("req_held_waiting", REQ, 1);
            end
            if (p_idle && p_start) check("start_accept_busy_req", {busy, REQ}, 3);
            if (addr_phase) begin
                acyc++;
                check("addr_phase_ctl", {FRAME_out_n, IRDY_out_n, ctl_oe, REQ}, 4'b0111);
            end
            if (!IRDY_out_n) begin
                dcyc++;
                if (exp_q.size() > 0)
                    check("frame_last_beat", FRAME_out_n, int'(exp_q[0].le - acks == 1));
                if (data_ack) acks++;
            end else if (data_ack) begin
                check("data_ack_outside_data", data_ack, 0);
            end
            if (done) begin
                check("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("status", status, e.st);
                    check("beats_done", beats_done, e.beats);
                    check("data_cycles", dcyc, e.ncyc);
                    check("data_acks", acks, e.beats);
                    check("addr_cycles", acyc, 1);
                    check("idle_outputs", {busy, ctl_oe, REQ, IRDY_out_n}, 1);
                end
                dcyc = 0; acks = 0; acyc = 0;
            end
            p_rw    = REQ && !ctl_oe;
            p_go    = GNT && FRAME_in_n && IRDY_in_n;
            p_idle  = !busy;
            p_start = start;
        end
    end

    task automatic issue(input int len, input int dev, input int stp, input int disc,
                         input int abrt, input int gnt, input int bf, input int bi,
                         input bit all_trdy);
        exp_t x;
        int st, bt, nc, i;
        s_len = len; s_dev = dev; s_stop = stp; s_disc = disc; s_abort = abrt;
        s_gnt = gnt; s_bf = bf; s_bi = bi;
        for (int k = 0; k < 64; k++)
            trdy_pat[k] = all_trdy || (k >= 40) || ($urandom_range(3) != 0);
        model(st, bt, nc);
        x.le = (len == 0) ? 1 : len;
        x.st = st;
        x.beats = bt;
        x.ncyc = nc;
        exp_q.push_back(x);
        burst_len = CNT_W'(len);
        start = 1;
        for (i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (busy) break;
        end
        check("start_accepted", int'(i < 50), 1);
        start = 0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        check("done_within_budget", int'(i < 300), 1);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [14:0] RST_VEC = 15'h3000;

    int len, dev, stp, disc, ab, gnt, bf, bi;
    initial begin
        reset_n = 0; start = 0; burst_len = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {REQ, FRAME_out_n, IRDY_out_n, ctl_oe, addr_phase, busy, done, status, beats_done, data_ack},
              RST_VEC);
        @(posedge clk); #1;
        reset_n = 1;
        gap(2);

        issue(4, 0, 0, -1, 0, 0, 0, 0, 1); wait_done(); gap(1);
        issue(3, 0, 0, -1, 0, 0, 5, 0, 1); wait_done(); gap(1);
        issue(2, 99, 0, -1, 0, 1, 0, 2, 1); wait_done();
        issue(8, 0, 3, -1, 0, 0, 0, 0, 1); wait_done(); gap(2);
        issue(5, 1, 0, 3, 0, 2, 1, 1, 1); wait_done(); gap(1);
        issue(4, 0, 0, -1, 2, 0, 0, 0, 1); wait_done(); gap(1);

        // Reset mid-burst: outputs must drop immediately, not at the next edge.
        issue(20, 0, 0, -1, 0, 0, 0, 0, 1);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 0;
        #1;
        check("reset_mid_data",
              {REQ, FRAME_out_n, IRDY_out_n, ctl_oe, addr_phase, busy, done, status, beats_done, data_ack},
              RST_VEC);
        exp_q.delete();
        gap(2);
        reset_n = 1;
        gap(1);
        issue(0, 0, 0, -1, 0, 0, 0, 0, 1); wait_done(); gap(1);

        for (int n = 0; n < 40; n++) begin
            len  = $urandom_range(10);
            dev  = ($urandom_range(7) == 0) ? 99 : $urandom_range(3);
            stp  = ($urandom_range(3) == 0) ? $urandom_range(10, 1) : 0;
            disc = ($urandom_range(4) == 0) ? $urandom_range(12) : -1;
            ab   = ($urandom_range(4) == 0) ? dev + $urandom_range(8, 1) : 0;
            gnt  = $urandom_range(3);
            bf   = $urandom_range(4);
            bi   = $urandom_range(2);
            issue(len, dev, stp, disc, ab, gnt, bf, bi, 1'($urandom_range(3) == 0));
            wait_done();
            if ($urandom_range(2) != 0) gap($urandom_range(3, 1));
        end
        gap(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
